// File: rtl/enc_8b10b_pkg.sv
// Shared types and constants for the multi-symbol 8b/10b encoder.
package enc_8b10b_pkg;

  // Comma character {k, HGF EDCBA}; it is also the idle fill symbol
  localparam logic [8:0] K28_5 = 9'h1BC;

  // K28.5 as it appears on out_data, packed {j,h,g,f,i,e,d,c,b,a}
  localparam logic [9:0] K28_5_RDN = 10'h17C;
  localparam logic [9:0] K28_5_RDP = 10'h283;

  // One control-tagged byte
  typedef struct packed {
    logic       k;
    logic [7:0] data;
  } sym_t;

endpackage

// File: rtl/enc_8b10b_sym.sv
// Single-symbol 8b/10b encoder, purely combinational.
// The tables hold the RD- form of each sub-block (MSB = a or f). The RD+ form
// is the complement, but only for unbalanced codes and for the two neutral
// codes that still alternate (D.7 in 5b/6b, D.x.3 in 3b/4b).
// Any K code outside K28.y / K23,27,29,30.7 goes through the same data path
// (A7 forced when y=7) and is reported on illegal_k.
module enc_8b10b_sym (
  input  logic       k,
  input  logic [7:0] data,
  input  logic       rd_in,
  output logic [9:0] code,
  output logic       rd_out,
  output logic       illegal_k
);

  logic [4:0] x;
  logic [2:0] y;
  logic       k28;
  logic [5:0] b6, c6;
  logic [3:0] b4, c4;
  logic       unbal6, flip6, rd_mid, a7, unbal4, flip4;

  assign x   = data[4:0];
  assign y   = data[7:5];
  assign k28 = k & (x == 5'd28);

  // 5b/6b lookup, RD- form
  always_comb begin
    b6 = 6'b000000;
    case (x)
      5'd0:  b6 = 6'b100111;  5'd1:  b6 = 6'b011101;
      5'd2:  b6 = 6'b101101;  5'd3:  b6 = 6'b110001;
      5'd4:  b6 = 6'b110101;  5'd5:  b6 = 6'b101001;
      5'd6:  b6 = 6'b011001;  5'd7:  b6 = 6'b111000;
      5'd8:  b6 = 6'b111001;  5'd9:  b6 = 6'b100101;
      5'd10: b6 = 6'b010101;  5'd11: b6 = 6'b110100;
      5'd12: b6 = 6'b001101;  5'd13: b6 = 6'b101100;
      5'd14: b6 = 6'b011100;  5'd15: b6 = 6'b010111;
      5'd16: b6 = 6'b011011;  5'd17: b6 = 6'b100011;
      5'd18: b6 = 6'b010011;  5'd19: b6 = 6'b110010;
      5'd20: b6 = 6'b001011;  5'd21: b6 = 6'b101010;
      5'd22: b6 = 6'b011010;  5'd23: b6 = 6'b111010;
      5'd24: b6 = 6'b110011;  5'd25: b6 = 6'b100110;
      5'd26: b6 = 6'b010110;  5'd27: b6 = 6'b110110;
      5'd28: b6 = 6'b001110;  5'd29: b6 = 6'b101110;
      5'd30: b6 = 6'b011110;  default: b6 = 6'b101011;
    endcase
    if (k28) b6 = 6'b001111;
  end

  assign unbal6 = ($countones(b6) != 3);
  assign flip6  = rd_in & (unbal6 | (b6 == 6'b111000));
  assign c6     = flip6 ? ~b6 : b6;
  assign rd_mid = rd_in ^ unbal6;

  // Alternate x.7 avoids a run of five equal bits across the sub-block seam
  assign a7 = (y == 3'd7) &
              (k | (~rd_mid & ((x == 5'd17) | (x == 5'd18) | (x == 5'd20)))
                 | ( rd_mid & ((x == 5'd11) | (x == 5'd13) | (x == 5'd14))));

  // 3b/4b lookup, RD- form
  always_comb begin
    b4 = 4'b0000;
    case (y)
      3'd0: b4 = 4'b1011;
      3'd1: b4 = 4'b1001;
      3'd2: b4 = 4'b0101;
      3'd3: b4 = 4'b1100;
      3'd4: b4 = 4'b1101;
      3'd5: b4 = 4'b1010;
      3'd6: b4 = 4'b0110;
      default: b4 = a7 ? 4'b0111 : 4'b1110;
    endcase
  end

  assign unbal4 = (y == 3'd0) | (y == 3'd4) | (y == 3'd7);
  // K28 also alternates its neutral 4b codes so that commas stay unique
  assign flip4  = (rd_mid & (unbal4 | (y == 3'd3)))
                | (k28 & ~rd_mid & ((y == 3'd1) | (y == 3'd2) | (y == 3'd5) | (y == 3'd6)));
  assign c4     = flip4 ? ~b4 : b4;
  assign rd_out = rd_mid ^ unbal4;

  // Wire order: a first, packed {j,h,g,f,i,e,d,c,b,a}
  assign code = {c4[0], c4[1], c4[2], c4[3], c6[0], c6[1], c6[2], c6[3], c6[4], c6[5]};

  assign illegal_k = k & ~(k28 | ((y == 3'd7) &
                     ((x == 5'd23) | (x == 5'd27) | (x == 5'd29) | (x == 5'd30))));

endmodule

// File: rtl/enc_8b10b_lanes.sv
// NSYM-wide 8b/10b encoder with a single registered output stage.
// Running disparity is chained symbol 0 -> NSYM-1 within a beat and held in
// rd_q between beats. Optional idle fill (K28.5 beats when no input is
// offered) is enabled by defining MPHY_ENC_IDLE_FILL_EN.
module enc_8b10b_lanes
  import enc_8b10b_pkg::*;
#(
  parameter int NSYM = 2,
  parameter int ERRW = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [8*NSYM-1:0] in_data,
  input  logic [NSYM-1:0]   in_k,
  input  logic              rd_load,
  input  logic              rd_value,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [10*NSYM-1:0] out_data,
  output logic [NSYM-1:0]   out_illegal_k,
  output logic              rd_out,
  output logic [ERRW-1:0]   err_count
);

  localparam int SW = ERRW + 4;
  localparam logic [SW-1:0] ERR_MAX = SW'({ERRW{1'b1}});

  logic                 vld_q, rd_q;
  logic [NSYM-1:0][9:0] code_q, code_d;
  logic [NSYM-1:0]      ill_q, ill_d;
  logic [ERRW-1:0]      err_q, err_d;
  logic [SW-1:0]        err_sum;
  logic                 accept, fill, load;
  logic [NSYM:0]        rd_chain;
  sym_t [NSYM-1:0]      sym;

  assign in_ready = ~vld_q | out_ready;
  assign accept   = in_valid & in_ready;
`ifdef MPHY_ENC_IDLE_FILL_EN
  assign fill     = ~in_valid & in_ready;
`else
  assign fill     = 1'b0;
`endif
  assign load     = accept | fill;

  // A preset in the accept cycle seeds this beat directly
  assign rd_chain[0] = rd_load ? rd_value : rd_q;

  for (genvar g = 0; g < NSYM; g++) begin : g_sym
    assign sym[g] = fill ? sym_t'(K28_5) : {in_k[g], in_data[8*g +: 8]};

    enc_8b10b_sym u_sym (
      .k         (sym[g].k),
      .data      (sym[g].data),
      .rd_in     (rd_chain[g]),
      .code      (code_d[g]),
      .rd_out    (rd_chain[g+1]),
      .illegal_k (ill_d[g])
    );
  end

  // Saturating add of this beat's illegal-K popcount
  always_comb begin
    err_sum = SW'(err_q);
    for (int i = 0; i < NSYM; i++) err_sum = err_sum + SW'(ill_d[i] & accept);
    err_d = (err_sum > ERR_MAX) ? {ERRW{1'b1}} : err_sum[ERRW-1:0];
  end

  // Output stage, RD register and error counter
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q  <= 1'b0;
      code_q <= '0;
      ill_q  <= '0;
      rd_q   <= 1'b0;
      err_q  <= '0;
    end else begin
      if (load) begin
        vld_q  <= 1'b1;
        code_q <= code_d;
        ill_q  <= ill_d;
        rd_q   <= rd_chain[NSYM];
      end else begin
        if (rd_load)   rd_q  <= rd_value;
        if (out_ready) vld_q <= 1'b0;
      end
      err_q <= err_d;
    end
  end

  assign out_valid     = vld_q;
  assign out_data      = code_q;
  assign out_illegal_k = ill_q;
  assign rd_out        = rd_q;
  assign err_count     = err_q;

endmodule

// File: tb/tb_enc_8b10b_lanes.sv
// Bench for enc_8b10b_lanes (NSYM=2, ERRW=2): directed beats with known code
// words, then randomized traffic against a table-driven reference model.
module tb_enc_8b10b_lanes;
  import enc_8b10b_pkg::*;

  localparam int NSYM = 2;
  localparam int ERRW = 2;
  localparam int EMAX = (1 << ERRW) - 1;

  logic clk = 1'b0;
  logic reset, in_valid, in_ready, rd_load, rd_value, out_valid, out_ready, rd_out;
  logic [8*NSYM-1:0]  in_data;
  logic [NSYM-1:0]    in_k, out_illegal_k;
  logic [10*NSYM-1:0] out_data;
  logic [ERRW-1:0]    err_count;

  always #5 clk = ~clk;

  enc_8b10b_lanes #(.NSYM(NSYM), .ERRW(ERRW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_k(in_k), .rd_load(rd_load), .rd_value(rd_value),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_illegal_k(out_illegal_k), .rd_out(rd_out), .err_count(err_count)
  );

  // Standard code tables, abcdei / fghj with a (or f) as MSB
  logic [5:0] T6N [32] = '{6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001,
    6'b011001, 6'b111000, 6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100,
    6'b011100, 6'b010111, 6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010,
    6'b011010, 6'b111010, 6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110,
    6'b011110, 6'b101011};
  logic [5:0] T6P [32] = '{6'b011000, 6'b100010, 6'b010010, 6'b110001, 6'b001010, 6'b101001,
    6'b011001, 6'b000111, 6'b000110, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100,
    6'b011100, 6'b101000, 6'b100100, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010,
    6'b011010, 6'b000101, 6'b001100, 6'b100110, 6'b010110, 6'b001001, 6'b001110, 6'b010001,
    6'b100001, 6'b010100};
  logic [3:0] T4N [8] = '{4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b1110};
  logic [3:0] T4P [8] = '{4'b0100, 4'b1001, 4'b0101, 4'b0011, 4'b0010, 4'b1010, 4'b0110, 4'b0001};
  logic [9:0] K28N [8] = '{10'b0011110100, 10'b0011111001, 10'b0011110101, 10'b0011110011,
    10'b0011110010, 10'b0011111010, 10'b0011110110, 10'b0011111000};
  logic [9:0] K28P [8] = '{10'b1100001011, 10'b1100000110, 10'b1100001010, 10'b1100001100,
    10'b1100001101, 10'b1100000101, 10'b1100001001, 10'b1100000111};
  logic [7:0] KLEG [12] = '{8'hBC, 8'h1C, 8'h3C, 8'h5C, 8'h7C, 8'h9C, 8'hDC, 8'hFC,
    8'hF7, 8'hFB, 8'hFD, 8'hFE};

  int n_chk = 0, n_err = 0;

  // Reference state
  logic               m_ov, m_rd;
  logic [10*NSYM-1:0] m_data;
  logic [NSYM-1:0]    m_ill;
  int                 m_err;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Disparity after a sub-block: more ones -> RD+, fewer -> RD-, equal -> unchanged
  function automatic logic rd_after(input logic rd, input int ones, input int n);
    if (2*ones > n) return 1'b1;
    if (2*ones < n) return 1'b0;
    return rd;
  endfunction

  // Encode one symbol; result is abcdeifghj reversed onto the wire order
  function automatic void ref_enc(input logic k, input logic [7:0] d, input logic rdi,
                                  output logic [9:0] code, output logic rdo, output logic ill);
    int x, y;
    logic [9:0] s;
    logic [5:0] s6;
    logic [3:0] s4;
    logic rdm, alt;
    x = int'(d[4:0]);
    y = int'(d[7:5]);
    ill = k && !(x == 28 || (y == 7 && (x == 23 || x == 27 || x == 29 || x == 30)));
    if (k && x == 28) begin
      s   = rdi ? K28P[y] : K28N[y];
      rdo = rd_after(rdi, $countones(s), 10);
    end else begin
      s6  = rdi ? T6P[x] : T6N[x];
      rdm = rd_after(rdi, $countones(s6), 6);
      alt = (y == 7) && (k || (!rdm && (x == 17 || x == 18 || x == 20)) ||
                              (rdm && (x == 11 || x == 13 || x == 14)));
      if (alt) s4 = rdm ? 4'b1000 : 4'b0111;
      else     s4 = rdm ? T4P[y] : T4N[y];
      rdo = rd_after(rdm, $countones(s4), 4);
      s   = {s6, s4};
    end
    for (int i = 0; i < 10; i++) code[i] = s[9-i];
  endfunction

  // One clock: drive, check in_ready, advance model at the edge, check outputs
  task automatic step(input logic iv, input logic [8*NSYM-1:0] d, input logic [NSYM-1:0] k,
                      input logic rl, input logic rv, input logic ordy, input logic rst);
    logic rdy, acc, fl, r, rdo, il;
    logic [9:0] c;
    int cnt;
    in_valid = iv; in_data = d; in_k = k; rd_load = rl; rd_value = rv;
    out_ready = ordy; reset = rst;
    #1;
    rdy = !m_ov || ordy;
    chk("in_ready", in_ready, rdy);
    @(posedge clk);
    if (rst) begin
      m_ov = 0; m_rd = 0; m_data = '0; m_ill = '0; m_err = 0;
    end else begin
      acc = iv && rdy;
      fl  = 0;
`ifdef MPHY_ENC_IDLE_FILL_EN
      fl  = !iv && rdy;
`endif
      if (acc || fl) begin
        r = rl ? rv : m_rd;
        cnt = 0;
        for (int i = 0; i < NSYM; i++) begin
          ref_enc(fl ? 1'b1 : k[i], fl ? 8'hBC : d[8*i +: 8], r, c, rdo, il);
          m_data[10*i +: 10] = c;
          m_ill[i] = il;
          if (il && acc) cnt++;
          r = rdo;
        end
        m_rd  = r;
        m_ov  = 1;
        m_err = (m_err + cnt > EMAX) ? EMAX : m_err + cnt;
      end else begin
        if (rl) m_rd = rv;
        if (ordy) m_ov = 0;
      end
    end
    @(negedge clk);
    chk("out_valid", out_valid, m_ov);
    chk("out_data", out_data, m_data);
    chk("out_illegal_k", out_illegal_k, m_ill);
    chk("rd_out", rd_out, m_rd);
    chk("err_count", err_count, m_err);
  endtask

  logic [19:0] e_kk, e_d, e_kd;
  logic [7:0]  b;
  logic [15:0] rdat;
  logic [1:0]  rk;

  initial begin
    m_ov = 0; m_rd = 0; m_data = '0; m_ill = '0; m_err = 0;
    reset = 1; in_valid = 0; in_data = '0; in_k = '0; rd_load = 0; rd_value = 0; out_ready = 1;
    @(negedge clk);
    step(0, '0, '0, 0, 0, 1, 1);
    step(0, '0, '0, 0, 0, 1, 1);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_rd", rd_out, 0);
    chk("rst_err", err_count, 0);

    e_kk = {K28_5_RDP, K28_5_RDN};
    e_d  = {10'h155, 10'h0B9};
    e_kd = {10'h155, K28_5_RDP};

`ifdef MPHY_ENC_IDLE_FILL_EN
    // Idle: continuous K28.5 fill, alternating per symbol
    for (int i = 0; i < 6; i++) begin
      step(0, '0, '0, 0, 0, 1, 0);
      chk("fill_valid", out_valid, 1);
      chk("fill_data", out_data, e_kk);
    end
`else
    step(1, 16'hBCBC, 2'b11, 0, 0, 1, 0);
    chk("k285_pair", out_data, e_kk);
    chk("k285_rd", rd_out, 0);
    step(1, 16'hB500, 2'b00, 0, 0, 1, 0);
    chk("d0_d21", out_data, e_d);
    chk("d0_d21_rd", rd_out, 0);

    // Stall: first beat held for three cycles, second beat waits
    step(1, 16'hBCBC, 2'b11, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 16'hB500, 2'b00, 0, 0, 0, 0);
      chk("stall_ready", in_ready, 0);
      chk("stall_data", out_data, e_kk);
    end
    step(1, 16'hB500, 2'b00, 0, 0, 1, 0);
    chk("release_data", out_data, e_d);
    step(0, '0, '0, 0, 0, 1, 0);
    chk("drain_valid", out_valid, 0);

    // Preset RD+ in the accept cycle
    step(1, 16'hB5BC, 2'b01, 1, 1, 1, 0);
    chk("rdload_data", out_data, e_kd);
    chk("rdload_rd", rd_out, 0);

    // Illegal K0.0 and counter saturation
    step(1, 16'h0000, 2'b01, 0, 0, 1, 0);
    chk("illk_flag", out_illegal_k, 2'b01);
    chk("illk_cnt1", err_count, 1);
    for (int i = 0; i < 4; i++) step(1, 16'h0000, 2'b01, 0, 0, 1, 0);
    chk("illk_sat", err_count, 3);

    // Preset alone while idle
    step(0, '0, '0, 1, 1, 1, 0);
    chk("rdload_idle", rd_out, 1);
    step(0, '0, '0, 0, 0, 1, 0);
    chk("rd_hold_idle", rd_out, 1);
`endif

    // Randomized traffic with stalls, presets and occasional resets
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < NSYM; i++) begin
        rk[i] = ($urandom_range(3) == 0);
        b = 8'($urandom);
        if (rk[i] && $urandom_range(2) != 0) b = KLEG[$urandom_range(11)];
        rdat[8*i +: 8] = b;
      end
      step($urandom_range(3) != 0, rdat, rk, $urandom_range(9) == 0, 1'($urandom),
           $urandom_range(3) != 0, $urandom_range(49) == 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/enc_8b10b_lanes.md
Name: enc_8b10b_lanes

Overview:
- Parametrised multi-symbol 8b/10b encoder (Widmer–Franaszek code) for the M-PHY transmit datapath.
- Encodes NSYM control-tagged bytes per clock, symbol 0 first on the wire.
- Running disparity (RD) is chained through the symbols of one beat and held across beats.
- Valid/ready handshake on both sides with one registered output stage. Adds RD preset, per-symbol illegal-K flagging and a sticky error count.

Parameters:
- NSYM, 2, symbols per beat (1..8).
- ERRW, 8, width of the saturating illegal-K counter.

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid & in_ready
- in_data  in  8*NSYM  byte i at [8i+7:8i], bit0 = A
- in_k  in  NSYM  bit i: byte i is a control (K) symbol
- rd_load  in  1  preset running disparity
- rd_value  in  1  preset value (0 = RD-, 1 = RD+)
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts
- out_data  out  10*NSYM  symbol i at [10i+9:10i], bit order {j,h,g,f,i,e,d,c,b,a}
- out_illegal_k  out  NSYM  symbol i was a K code outside K28.0–7, K23/27/29/30.7
- rd_out  out  1  current running disparity register
- err_count  out  ERRW  saturating count of illegal K symbols accepted

Behaviour:
- Reset values: out_valid=0, out_data=0, out_illegal_k=0, rd_out=0 (RD-), err_count=0.
- in_ready = !out_valid | out_ready. Combinational; no path from in_valid.
- On accept:
  - Symbol 0 is encoded with RD = rd register; symbol i uses the disparity out of symbol i-1.
  - All results are registered into out_data / out_illegal_k.
  - out_valid is set to 1.
  - The rd register takes the disparity out of symbol NSYM-1.
- Latency: exactly 1 cycle from accept to out_valid.
- Stall (out_valid & !out_ready): out_data, out_illegal_k and rd are held stable; in_ready=0.
- out_valid clears when out_ready=1 and no new beat is accepted in the same cycle.
- The RD register changes only on accept or rd_load, never on idle cycles.
- Per-symbol coding:
  - 5b/6b and 3b/4b tables with complementing per RD.
  - Alternate Dx.A7 is used for D17/18/20 at RD- and for D11/13/14 at RD+.
  - Every K.7 uses the A7 form.
- Illegal K code: still encoded by the same logic, not substituted; flagged in out_illegal_k.
- err_count: increments by popcount of illegal-K symbols per accepted beat and saturates at 2^ERRW-1.
- rd_load:
  - Alone: rd <= rd_value.
  - Same cycle as an accept: rd_value seeds symbol 0 of that beat instead of the rd register. The beat's final disparity is stored.
- Reset mid-stall discards the held beat.

Optional Feature:
- Macro: MPHY_ENC_IDLE_FILL_EN.
- Enabled:
  - When in_valid=0 and the output slot is free (!out_valid | out_ready), the block injects a fill beat of NSYM K28.5 symbols.
  - Fill beats are encoded with normal RD chaining and drive out_valid=1.
  - out_valid is therefore 1 from the first cycle after reset deasserts.
  - Fill symbols are never flagged illegal.
- Disabled: no injection; out_valid follows accepted beats only.

Decomposition:
- Package enc_8b10b_pkg holds:
  - K28_5 = 9'h1BC.
  - Encoded constants K28_5_RDN = 10'h17C and K28_5_RDP = 10'h283.
  - A symbol struct {k, data[7:0]}.
- Sub-module enc_8b10b_sym: purely combinational single-symbol encoder with ports (k, data, rd_in) -> (code[9:0], rd_out, illegal_k). It is instantiated NSYM times in a generate chain. The top holds the handshake, RD register and counter.

Test Plan:
- NSYM=2, reset, beat {K28.5, K28.5} -> next cycle out_data={10'h283, 10'h17C} (sym0=0x17C), rd_out=0.
- Beat {D0.0, D21.5} from RD- -> sym0=0x0B9, sym1=0x155, rd_out=0.
- Hold out_ready=0 for 3 cycles after a beat -> in_ready=0, out_data/rd_out unchanged; release -> next beat accepted with no loss or duplicate.
- rd_load=1, rd_value=1 with beat {K28.5, D21.5} -> sym0=0x283, sym1=0x155, rd_out=0.
- Beat with in_k=2'b01, data byte0=8'h00 (K0.0) -> out_illegal_k=2'b01, err_count=1; with ERRW=2, repeat 5 times -> err_count=3.
- With MPHY_ENC_IDLE_FILL_EN and in_valid=0 after reset -> alternating sym values 0x17C/0x283 on the wire and continuous out_valid=1.
